// File: rtl/flux_fifo_pkg.sv
// rtl/flux_fifo_pkg.sv - shared types, defaults and helpers for the tagged flux FIFO
package flux_fifo_pkg;

    localparam int FLUX_DEF       = 2;
    localparam int DATA_WIDTH_DEF = 18;
    localparam int DEPTH_DEF      = 8;
    localparam int TAG_WIDTH_DEF  = $clog2(FLUX_DEF);
    localparam int MAX_FLUX       = 32;

    typedef logic [TAG_WIDTH_DEF-1:0] flux_tag_t;

    typedef struct packed {
        flux_tag_t                 tag;
        logic [DATA_WIDTH_DEF-1:0] data;
    } token_t;

    // Isolate the lowest set bit; zero input gives zero.
    function automatic logic [MAX_FLUX-1:0] onehot_lsb(input logic [MAX_FLUX-1:0] v);
        return v & (~v + MAX_FLUX'(1));
    endfunction

    // Pointer wrap relies on natural binary overflow, so depth must be a power of two.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/flux_fifo_bank.sv
// rtl/flux_fifo_bank.sv - single-flux first-word-fall-through FIFO
module flux_fifo_bank
    import flux_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy; callers only assert wr_en when !full and rd_en when !empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/tagged_flux_fifo.sv
// rtl/tagged_flux_fifo.sv - multi-flux tagged FIFO; error flags enabled by FLUX_FIFO_ERR_EN
module tagged_flux_fifo
    import flux_fifo_pkg::*;
#(
    parameter int  FLUX       = FLUX_DEF,
    parameter int  DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int  DEPTH      = DEPTH_DEF,
    localparam int TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [TAG_WIDTH+DATA_WIDTH-1:0] wr_din,
    input  logic                          wr_write,
    output logic [FLUX-1:0]               wr_full,
    input  logic [FLUX-1:0]               rd_read,
    output logic [FLUX-1:0]               rd_empty,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] rd_dout,
    output logic [FLUX-1:0]               err_ovf,
    output logic [FLUX-1:0]               err_udf
);

    if (!is_pow2(DEPTH)) begin : g_depth_check
        $error("tagged_flux_fifo: DEPTH must be a power of two >= 2");
    end

    logic [TAG_WIDTH-1:0]  wr_tag;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  tag_ok;
    logic [FLUX-1:0]       tag_hit;
    logic [FLUX-1:0]       wr_en;
    logic [FLUX-1:0]       rd_sel;
    logic [FLUX-1:0]       rd_en;
    logic [FLUX-1:0]       full;
    logic [FLUX-1:0]       empty;
    logic [DATA_WIDTH-1:0] head [FLUX];

    assign wr_tag  = wr_din[TAG_WIDTH+DATA_WIDTH-1 -: TAG_WIDTH];
    assign wr_data = wr_din[DATA_WIDTH-1:0];
    assign tag_ok  = (int'(wr_tag) < FLUX);
    // Multi-hot reads are served on the lowest set index only.
    assign rd_sel  = FLUX'(onehot_lsb(MAX_FLUX'(rd_read)));

    for (genvar f = 0; f < FLUX; f++) begin : g_flux
        assign tag_hit[f] = tag_ok && (wr_tag == TAG_WIDTH'(f));
        assign wr_en[f]   = wr_write && tag_hit[f] && !full[f];
        assign rd_en[f]   = rd_sel[f] && !empty[f];

        flux_fifo_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_en[f]),
            .wr_data (wr_data),
            .rd_en   (rd_en[f]),
            .rd_data (head[f]),
            .full    (full[f]),
            .empty   (empty[f])
        );
    end

    assign wr_full  = full;
    assign rd_empty = empty;

    // Head of the served flux tagged with its index; zero when nothing is served.
    always_comb begin
        rd_dout = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (rd_en[f]) begin
                rd_dout = {TAG_WIDTH'(f), head[f]};
            end
        end
    end

`ifdef FLUX_FIFO_ERR_EN
    logic [FLUX-1:0] ovf_q;
    logic [FLUX-1:0] udf_q;
    logic [FLUX-1:0] ovf_set;
    logic [FLUX-1:0] udf_set;
    logic            multi_hot;

    assign multi_hot = |(rd_read & ~rd_sel);

    // Dropped writes with an out-of-range tag have no flag bit to land on.
    always_comb begin
        ovf_set = '0;
        for (int f = 0; f < FLUX; f++) begin
            if (wr_write && tag_hit[f] && full[f]) begin
                ovf_set[f] = 1'b1;
            end
        end
        udf_set = multi_hot ? rd_read : (rd_read & empty);
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            udf_q <= '0;
        end else begin
            ovf_q <= ovf_q | ovf_set;
            udf_q <= udf_q | udf_set;
        end
    end

    assign err_ovf = ovf_q;
    assign err_udf = udf_q;
`else
    assign err_ovf = '0;
    assign err_udf = '0;
`endif

endmodule

// File: tb/tb_tagged_flux_fifo.sv
// tb/tb_tagged_flux_fifo.sv - randomized self-checking bench for tagged_flux_fifo
module tb_tagged_flux_fifo;
    import flux_fifo_pkg::*;

    localparam int FLUX  = 2;
    localparam int DW    = 18;
    localparam int DEPTH = 8;
`ifdef FLUX_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW:0]   wr_din;
    logic          wr_write;
    logic [1:0]    wr_full;
    logic [1:0]    rd_read;
    logic [1:0]    rd_empty;
    logic [DW:0]   rd_dout;
    logic [1:0]    err_ovf;
    logic [1:0]    err_udf;

    tagged_flux_fifo #(.FLUX(FLUX), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_din   (wr_din),
        .wr_write (wr_write),
        .wr_full  (wr_full),
        .rd_read  (rd_read),
        .rd_empty (rd_empty),
        .rd_dout  (rd_dout),
        .err_ovf  (err_ovf),
        .err_udf  (err_udf)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] q [FLUX][$];
    logic [1:0]    m_ovf;
    logic [1:0]    m_udf;

    logic [DW:0]   obs_dout;
    logic [1:0]    obs_empty;
    logic [1:0]    obs_full;
    logic [1:0]    obs_ovf;
    logic [1:0]    obs_udf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < FLUX; f++) q[f].delete();
        m_ovf = '0;
        m_udf = '0;
    endtask

    // One clock cycle: drive at negedge, compare against the queue model, then advance the model.
    task automatic drive(input bit wr, input int tag, input logic [DW-1:0] data, input logic [1:0] rd);
        token_t      tok;
        int          sel;
        bit          wr_ok;
        logic [DW:0] exp_dout;
        logic [1:0]  exp_empty;
        logic [1:0]  exp_full;
        @(negedge clk);
        rst      = 1'b0;
        tok.tag  = flux_tag_t'(tag);
        tok.data = data;
        wr_din   = tok;
        wr_write = wr;
        rd_read  = rd;
        #1;
        sel = -1;
        for (int f = FLUX - 1; f >= 0; f--) if (rd[f]) sel = f;
        for (int f = 0; f < FLUX; f++) begin
            exp_empty[f] = (q[f].size() == 0);
            exp_full[f]  = (q[f].size() == DEPTH);
        end
        exp_dout = '0;
        if (sel >= 0 && q[sel].size() > 0) exp_dout = {sel[0], q[sel][0]};
        obs_dout  = rd_dout;
        obs_empty = rd_empty;
        obs_full  = wr_full;
        obs_ovf   = err_ovf;
        obs_udf   = err_udf;
        check_eq("rd_dout",  32'(obs_dout),  32'(exp_dout));
        check_eq("rd_empty", 32'(obs_empty), 32'(exp_empty));
        check_eq("wr_full",  32'(obs_full),  32'(exp_full));
        check_eq("err_ovf",  32'(obs_ovf),   ERR_EN ? 32'(m_ovf) : 32'(0));
        check_eq("err_udf",  32'(obs_udf),   ERR_EN ? 32'(m_udf) : 32'(0));
        wr_ok = wr && (q[tag].size() < DEPTH);
        if (wr && !wr_ok) m_ovf[tag] = 1'b1;
        if ($countones(rd) > 1) m_udf = m_udf | rd;
        else if (sel >= 0 && q[sel].size() == 0) m_udf[sel] = 1'b1;
        if (sel >= 0 && q[sel].size() > 0) void'(q[sel].pop_front());
        if (wr_ok) q[tag].push_back(data);
        @(posedge clk);
    endtask

    // Synchronous reset for one edge with random traffic on the inputs.
    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        wr_write = 1'($urandom_range(0, 1));
        wr_din   = (DW+1)'($urandom);
        rd_read  = 2'($urandom_range(0, 3));
        @(posedge clk);
        model_clear();
    endtask

    initial begin
        rst      = 1'b1;
        wr_write = 1'b0;
        wr_din   = '0;
        rd_read  = '0;
        model_clear();
        repeat (2) @(posedge clk);

        // 1: reset then idle
        drive(0, 0, 0, 2'b00);
        check_eq("t1_empty", 32'(obs_empty), 32'h3);
        check_eq("t1_full",  32'(obs_full),  32'h0);
        check_eq("t1_dout",  32'(obs_dout),  32'h0);

        // 2: one token per flux, read flux 1
        drive(1, 0, 18'h00005, 2'b00);
        drive(1, 1, 18'h3FFFF, 2'b00);
        drive(0, 0, 0, 2'b10);
        check_eq("t2_dout",   32'(obs_dout),     32'h7FFFF);
        check_eq("t2_empty1", 32'(obs_empty[1]), 32'h0);
        drive(0, 0, 0, 2'b00);
        check_eq("t2_empty1_after", 32'(obs_empty[1]), 32'h1);

        // 3: fill flux 0 past full across pointer wrap, drain in order
        drive(0, 0, 0, 2'b01);
        check_eq("t3_pop5", 32'(obs_dout), 32'h5);
        for (int i = 1; i <= 8; i++) drive(1, 0, 18'(i), 2'b00);
        drive(1, 0, 18'h9, 2'b00);
        check_eq("t3_full", 32'(obs_full[0]), 32'h1);
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 0, 2'b01);
            check_eq("t3_order", 32'(obs_dout), 32'(i));
        end
        drive(0, 0, 0, 2'b00);
        check_eq("t3_ovf", 32'(obs_ovf[0]), 32'(ERR_EN));
        check_eq("t3_empty", 32'(obs_empty[0]), 32'h1);

        // 4: full flux, simultaneous write and read
        for (int i = 0; i < 8; i++) drive(1, 0, 18'(16 + i), 2'b00);
        drive(1, 0, 18'h99, 2'b01);
        check_eq("t4_dout", 32'(obs_dout), 32'd16);
        drive(0, 0, 0, 2'b00);
        check_eq("t4_full_clr", 32'(obs_full[0]), 32'h0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 2'b01);
            check_eq("t4_drain", 32'(obs_dout), 32'(17 + i));
        end

        // 5: empty flux, simultaneous write and read
        drive(1, 1, 18'h7, 2'b10);
        check_eq("t5_dout0", 32'(obs_dout), 32'h0);
        drive(0, 0, 0, 2'b10);
        check_eq("t5_dout", 32'(obs_dout), 32'h40007);
        check_eq("t5_udf", 32'(obs_udf[1]), 32'(ERR_EN));

        // 6: reset mid-stream
        for (int i = 0; i < 3; i++) drive(1, 0, 18'(40 + i), 2'b00);
        do_reset();
        drive(0, 0, 0, 2'b00);
        check_eq("t6_empty", 32'(obs_empty), 32'h3);
        check_eq("t6_udf",   32'(obs_udf),   32'h0);
        drive(1, 0, 18'h9, 2'b00);
        drive(0, 0, 0, 2'b01);
        check_eq("t6_val9", 32'(obs_dout), 32'h9);

        // Random traffic against the queue model
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 9) < 6, int'($urandom_range(0, 1)),
                      DW'($urandom), 2'($urandom_range(0, 3)));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
